inference_result_ctrl: RTL and testbench

- Run controller and result collector placed directly downstream of forward_pass.
- Drives the ap_ctrl_hs start handshake and captures each ap_return class on ap_done.
- Stores results with run sequence number and latency in a small FIFO, readable over the Caravel Wishbone slave port.
- Raises a user interrupt when results are pending; replaces the raw logic-analyzer start/return hookup in user_project_wrapper.

---
 rtl/inference_result_ctrl_pkg.sv | 45 ++++
 rtl/inference_result_ctrl_if.sv | 26 ++
 rtl/inference_result_ctrl_result_fifo.sv | 52 +++++
 rtl/inference_result_ctrl.sv | 169 ++++++++++++++++
 tb/tb_inference_result_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/inference_result_ctrl_pkg.sv
// Shared constants for inference_result_ctrl: register offsets, CTRL/STATUS bit
// positions, FSM state codes and the RESULT word packing helper.
package inference_ctrl_pkg;

  // Register offsets, taken from adr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_LAST   = 2'd3;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLUSH  = 3;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_TMO     = 4;
  localparam int STAT_CNT_LSB = 8;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_CAP  = 2'd3;

  // Result entry field widths
  localparam int LAT_W = 15;
  localparam int SEQ_W = 8;
  localparam int CLS_W = 8;

  // {valid, latency (saturated to 15 bits), seq, class}
  function automatic logic [31:0] pack_result(input logic [SEQ_W-1:0] seq,
                                              input logic [31:0] lat,
                                              input logic [CLS_W-1:0] cls);
    logic [LAT_W-1:0] l;
    l = (lat > 32'h0000_7FFF) ? 15'h7FFF : lat[LAT_W-1:0];
    return {1'b1, l, seq, cls};
  endfunction

endpackage

// File: rtl/inference_result_ctrl_if.sv
// Wishbone slave bus plus the ap_ctrl_hs handshake towards forward_pass.
// slave: the controller side; master: host / accelerator side (testbench).
interface inference_result_ctrl_if #(parameter int RET_W = 4);
  logic             wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i, wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic             ap_start;
  logic             ap_done, ap_idle, ap_ready;
  logic [RET_W-1:0] ap_return;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ap_start,
    input  ap_done, ap_idle, ap_ready, ap_return
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ap_start,
    output ap_done, ap_idle, ap_ready, ap_return
  );
endinterface

// File: rtl/inference_result_ctrl_result_fifo.sv
// Synchronous result FIFO with flush. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; flush overrides push and pop.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/inference_result_ctrl.sv
// Run controller / result collector for forward_pass: issues ap_start, captures
// ap_return on ap_done with seq and latency into result_fifo, exposes it over
// Wishbone and raises irq while results are pending.
// Optional watchdog: define INFER_TIMEOUT_EN.
module inference_result_ctrl
  import inference_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          RET_W          = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  inference_result_ctrl_if.slave bus,
  output logic                   irq,
  output logic                   core_rst_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       state;
  logic             cont, irq_en, ovf, tmo;
  logic [SEQ_W-1:0] seq;
  logic [31:0]      cyc_cnt, lat_q, last_cyc;
  logic [RET_W-1:0] ret_q;
  logic             hit, acc, wr, rd, go, timeout;
  logic [1:0]       reg_sel;
  logic [31:0]      rdata, dout;
  logic             push, pop, flush, full, empty, ovf_set;
  logic [CW-1:0]    count;

  assign hit     = bus.wbs_stb_i & bus.wbs_cyc_i & (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~bus.wbs_ack_o;
  assign wr      = acc & bus.wbs_we_i;
  assign rd      = acc & ~bus.wbs_we_i;
  assign reg_sel = bus.wbs_adr_i[3:2];

  assign flush   = wr && reg_sel == REG_CTRL && bus.wbs_dat_i[CTRL_FLUSH];
  assign pop     = rd && reg_sel == REG_RESULT && !empty;
  assign push    = (state == ST_CAP);
  assign ovf_set = push & full & ~pop & ~flush;
  assign go      = !core_rst_o &&
                   ((wr && reg_sel == REG_CTRL && bus.wbs_dat_i[CTRL_START]) || (cont && !full));
  assign bus.ap_start = (state == ST_REQ);

  result_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(ap_clk), .rst(ap_rst), .push(push), .pop(pop), .flush(flush),
    .din(pack_result(seq, lat_q, CLS_W'(ret_q))),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );

`ifdef INFER_TIMEOUT_EN
  logic [1:0] rst_cnt;
  // cyc_cnt doubles as the watchdog; a done in the same cycle wins
  assign timeout    = (state == ST_REQ || state == ST_WAIT) && !bus.ap_done &&
                      cyc_cnt >= TIMEOUT_CYCLES;
  assign core_rst_o = (rst_cnt != 2'd0);
  // Hold the core reset request for exactly two cycles after a timeout
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)            rst_cnt <= 2'd0;
    else if (timeout)      rst_cnt <= 2'd2;
    else if (core_rst_o)   rst_cnt <= rst_cnt - 2'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign core_rst_o = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{bus.wbs_sel_i, bus.ap_idle, bus.wbs_dat_i[31:5], bus.wbs_adr_i[1:0]};

  // Run FSM, latency counter and capture of the finished run
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      lat_q    <= '0;
      ret_q    <= '0;
      seq      <= '0;
      last_cyc <= '0;
    end else begin
      if (state != ST_IDLE && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      case (state)
        ST_IDLE: if (go) begin
          state   <= ST_REQ;
          cyc_cnt <= 32'd1;   // first REQ cycle counts as 1
        end
        ST_REQ: begin
          if (timeout) state <= ST_IDLE;
          else if (bus.ap_ready) begin
            if (bus.ap_done) begin
              state <= ST_CAP;
              lat_q <= cyc_cnt;
              ret_q <= bus.ap_return;
            end else state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timeout) state <= ST_IDLE;
          else if (bus.ap_done) begin
            state <= ST_CAP;
            lat_q <= cyc_cnt;
            ret_q <= bus.ap_return;
          end
        end
        default: begin
          seq      <= seq + SEQ_W'(1);
          last_cyc <= lat_q;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Control bits, sticky flags and the registered interrupt
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cont   <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      tmo    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && reg_sel == REG_CTRL) begin
        cont   <= bus.wbs_dat_i[CTRL_CONT];
        irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (ovf_set) ovf <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && bus.wbs_dat_i[STAT_OVF]) ovf <= 1'b0;
      if (timeout) tmo <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && bus.wbs_dat_i[STAT_TMO]) tmo <= 1'b0;
      irq <= irq_en & (~empty | ovf | tmo);
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_CONT]   = cont;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        rdata[STAT_BUSY]  = (state != ST_IDLE);
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_OVF]   = ovf;
        rdata[STAT_TMO]   = tmo;
        rdata[STAT_CNT_LSB +: 4] = 4'(count);
      end
      REG_RESULT: rdata = empty ? '0 : dout;
      default:    rdata = last_cyc;
    endcase
  end

  // Wishbone ack and read data, one cycle after the hit
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      bus.wbs_ack_o <= acc;
      bus.wbs_dat_o <= rd ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_inference_result_ctrl.sv
// Self-checking bench for inference_result_ctrl with a cycle-based forward_pass
// model and a scoreboard of expected RESULT words.
module tb_inference_result_ctrl;
  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_RESULT = 32'h3000_0008;
  localparam logic [31:0] A_LAST   = 32'h3000_000C;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic irq, core_rst_o;
  inference_result_ctrl_if #(.RET_W(4)) bus();

  inference_result_ctrl #(.BASE_ADDR(32'h3000_0000), .FIFO_DEPTH(4), .RET_W(4),
                          .TIMEOUT_CYCLES(32'd100)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus), .irq(irq), .core_rst_o(core_rst_o));

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0, n_err = 0;
  logic [31:0] sb[$];
  int rdy_dly = 3, done_dly = 10, done_en = 1, ret_val = 7;
  int m_busy = 0, m_t = 0, runs = 0, start_cycles = 0;
  int tb_seq = 0;

  // forward_pass model: ready/done at fixed offsets from the first ap_start cycle
  always begin
    @(posedge ap_clk); #1;
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b0;
    if (ap_rst || core_rst_o) m_busy = 0;
    else begin
      if (bus.ap_start) start_cycles++;
      if (bus.ap_start && m_busy == 0) begin m_busy = 1; m_t = 0; runs++; end
      if (m_busy != 0) begin
        if (m_t == rdy_dly) bus.ap_ready = 1'b1;
        if (m_t == done_dly && done_en != 0) begin
          bus.ap_done = 1'b1;
          bus.ap_return = 4'(ret_val);
          m_busy = 0;
        end
        m_t++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int lat, input int sq, input int cls);
    return {1'b1, 15'(lat), 8'(sq), 8'(cls)};
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rdat);
    bit got = 0;
    rdat = '0;
    @(negedge ap_clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;
    for (int i = 0; i < 8; i++) begin
      @(posedge ap_clk); #1;
      if (bus.wbs_ack_o) begin rdat = bus.wbs_dat_o; got = 1; break; end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    if (!got) chk("wb_ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'h0, rdat);
  endtask

  task automatic wait_status(input string tag, input logic [31:0] mask, input logic [31:0] val);
    logic [31:0] s = '0;
    for (int i = 0; i < 60; i++) begin
      wb_read(A_STATUS, s);
      if ((s & mask) == val) break;
    end
    chk(tag, s & mask, val);
  endtask

  task automatic rd_result(input string tag);
    logic [31:0] d, e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    wb_read(A_RESULT, d);
    chk(tag, d, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    chk(tag, d, exp);
  endtask

  initial begin
    int r0, s0;
    logic ack_seen;
    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.ap_done = 0; bus.ap_ready = 0; bus.ap_idle = 1; bus.ap_return = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_ap_start", 32'(bus.ap_start), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_core_rst", 32'(core_rst_o), 0);
    chk("rst_ack", 32'(bus.wbs_ack_o), 0);
    chk("rst_dat", bus.wbs_dat_o, 0);
    @(negedge ap_clk) ap_rst = 1'b0;
    rd_chk("rst_status", A_STATUS, 32'h2);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_last", A_LAST, 32'h0);

    // Single run: ready at +3, done at +10, class 7 -> latency 11
    rdy_dly = 3; done_dly = 10; ret_val = 7; s0 = start_cycles;
    sb.push_back(exp_word(11, tb_seq, 7)); tb_seq++;
    wb_write(A_CTRL, 32'h5);
    wait_status("run1_done", 32'h3, 32'h0);
    chk("run1_start_cycles", 32'(start_cycles - s0), 4);
    chk("run1_irq", 32'(irq), 1);
    rd_chk("run1_last", A_LAST, 32'd11);
    rd_result("run1_result");
    rd_chk("run1_status", A_STATUS, 32'h2);
    chk("run1_irq_clear", 32'(irq), 0);

    // Continuous mode fills the FIFO and stalls
    rdy_dly = 1; done_dly = 4; ret_val = 2; r0 = runs;
    for (int i = 0; i < 4; i++) begin sb.push_back(exp_word(5, tb_seq, 2)); tb_seq++; end
    wb_write(A_CTRL, 32'h6);
    wait_status("cont_full", 32'h4, 32'h4);
    repeat (20) @(posedge ap_clk);
    chk("cont_runs4", 32'(runs - r0), 4);
    rd_chk("cont_status_full", A_STATUS, 32'h404);
    sb.push_back(exp_word(5, tb_seq, 2)); tb_seq++;
    rd_result("cont_result_first");
    wait_status("cont_refill", 32'h4, 32'h4);
    wb_write(A_CTRL, 32'h4);
    repeat (20) @(posedge ap_clk);
    chk("cont_runs5", 32'(runs - r0), 5);

    // START with FIFO full: result dropped, OVF set, seq still advances
    wb_write(A_CTRL, 32'h5); tb_seq++;
    wait_status("ovf_done", 32'h1, 32'h0);
    rd_chk("ovf_status", A_STATUS, 32'h40C);
    wb_write(A_STATUS, 32'h8);
    rd_chk("ovf_w1c", A_STATUS, 32'h404);
    for (int i = 0; i < 4; i++) rd_result("ovf_drain");
    rd_chk("ovf_empty", A_STATUS, 32'h2);

    // ready and done together with the first ap_start
    rdy_dly = 0; done_dly = 0; ret_val = 10; s0 = start_cycles;
    sb.push_back(exp_word(1, tb_seq, 10)); tb_seq++;
    wb_write(A_CTRL, 32'h5);
    wait_status("fast_done", 32'h3, 32'h0);
    chk("fast_start_cycles", 32'(start_cycles - s0), 1);
    rd_chk("fast_single_push", A_STATUS, 32'h100);
    rd_chk("fast_last", A_LAST, 32'd1);
    rd_result("fast_result");
    rd_chk("empty_read", A_RESULT, 32'h0);
    rd_chk("empty_read_status", A_STATUS, 32'h2);

    // Async reset in the middle of WAIT
    rdy_dly = 1; done_dly = 4; ret_val = 3;
    sb.push_back(exp_word(5, tb_seq, 3)); tb_seq++;
    wb_write(A_CTRL, 32'h5);
    wait_status("pre_rst_done", 32'h3, 32'h0);
    chk("pre_rst_irq", 32'(irq), 1);
    done_en = 0;
    wb_write(A_CTRL, 32'h5);
    repeat (6) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst = 1'b1;
    #1;
    chk("arst_ap_start", 32'(bus.ap_start), 0);
    chk("arst_irq", 32'(irq), 0);
    @(negedge ap_clk) ap_rst = 1'b0;
    sb.delete(); tb_seq = 0; done_en = 1;
    rd_chk("arst_status", A_STATUS, 32'h2);
    rd_chk("arst_ctrl", A_CTRL, 32'h0);
    rdy_dly = 3; done_dly = 10; ret_val = 5;
    sb.push_back(exp_word(11, tb_seq, 5)); tb_seq++;
    wb_write(A_CTRL, 32'h1);
    wait_status("arst_run_done", 32'h3, 32'h0);
    rd_result("arst_result");

    // FLUSH empties the FIFO
    rdy_dly = 1; done_dly = 2; ret_val = 9; tb_seq++;
    wb_write(A_CTRL, 32'h1);
    wait_status("flush_run_done", 32'h3, 32'h0);
    rd_chk("flush_pre", A_STATUS, 32'h100);
    wb_write(A_CTRL, 32'h8);
    rd_chk("flush_post", A_STATUS, 32'h2);

    // Out-of-range address is never acked
    ack_seen = 1'b0;
    @(negedge ap_clk);
    bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3000_0010;
    repeat (4) begin @(posedge ap_clk); #1; ack_seen |= bus.wbs_ack_o; end
    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0;
    chk("miss_no_ack", 32'(ack_seen), 0);

`ifdef INFER_TIMEOUT_EN
    begin
      int n, hi;
      done_en = 0; n = 0; hi = 0;
      wb_write(A_CTRL, 32'h1);
      while (!core_rst_o && n < 300) begin @(posedge ap_clk); #1; n++; end
      chk("tmo_cycle", 32'(n), 32'd100);
      while (core_rst_o && hi < 10) begin hi++; @(posedge ap_clk); #1; end
      chk("tmo_pulse_len", 32'(hi), 32'd2);
      rd_chk("tmo_status", A_STATUS, 32'h12);
      wb_write(A_STATUS, 32'h10);
      rd_chk("tmo_w1c", A_STATUS, 32'h2);
      done_en = 1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
